// File: rtl/cap_seq.sv
// Purpose : camera capture sequencer; arms on start, aligns to the next vsync fall, gates N whole frames.
// Latency : cap_en_o/sof_o/eol_o are registered, 1 pclk after the href_i sample; done pulses 1 pclk after vsync rise.
// Backpr. : no stall path; a pixel seen while fifo_full_i=1 is dropped (cap_en_o=0) and err_ovf_o is set.
//
// Ports: pclk/rst_n (sync, active low); start_i/abort_i one-cycle requests; num_frames_i frames per run
// (0 = continuous, sampled on accepted start); vsync_i/href_i camera timing; fifo_full_i downstream full.
// Outputs: cap_en_o/sof_o/eol_o pixel strobes; busy_o; frame_done_o/run_done_o pulses; frames_o count;
// sticky err_hlen_o/err_vlen_o/err_ovf_o/err_tmo_o.
// Build option: define CAP_SEQ_TIMEOUT_EN to add the ARM/CAP watchdog (limit TIMEOUT_CYC pclk cycles).
module cap_seq #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int FRM_W       = 8,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [FRM_W-1:0] num_frames_i,
    input  logic             vsync_i,
    input  logic             href_i,
    input  logic             fifo_full_i,
    output logic             cap_en_o,
    output logic             sof_o,
    output logic             eol_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             run_done_o,
    output logic [FRM_W-1:0] frames_o,
    output logic             err_hlen_o,
    output logic             err_vlen_o,
    output logic             err_ovf_o,
    output logic             err_tmo_o
);
    // Counters are sized to hold one count past the nominal geometry so an
    // overlong line/frame is still distinguishable before saturating.
    localparam int PW = $clog2(H_ACTIVE + 2);
    localparam int LW = $clog2(V_ACTIVE + 2);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARM   = 2'd1;
    localparam logic [1:0] CAP   = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]       state;
    logic             vsync_d1;
    logic             href_d1;
    logic [PW-1:0]    pix_cnt;
    logic [LW-1:0]    line_cnt;
    logic [FRM_W-1:0] num_frames;

    logic             vsync_fall;
    logic             vsync_rise;
    logic             href_fall;
    logic             pix_take;
    logic [FRM_W-1:0] frames_nxt;

    assign vsync_fall = vsync_d1 & ~vsync_i;
    assign vsync_rise = ~vsync_d1 & vsync_i;
    assign href_fall  = href_d1 & ~href_i;
    // DRAIN keeps enabling pixels so an aborted line is delivered whole.
    assign pix_take   = href_i & ((state == CAP) | (state == DRAIN));
    assign frames_nxt = frames_o + FRM_W'(1);
    assign busy_o     = (state != IDLE);

`ifdef CAP_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd_cnt;
`else
    // Constant 0: the limit only matters when the watchdog is built.
    assign err_tmo_o = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state        <= IDLE;
            vsync_d1     <= 1'b0;
            href_d1      <= 1'b0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            num_frames   <= '0;
            frames_o     <= '0;
            cap_en_o     <= 1'b0;
            sof_o        <= 1'b0;
            eol_o        <= 1'b0;
            frame_done_o <= 1'b0;
            run_done_o   <= 1'b0;
            err_hlen_o   <= 1'b0;
            err_vlen_o   <= 1'b0;
            err_ovf_o    <= 1'b0;
`ifdef CAP_SEQ_TIMEOUT_EN
            err_tmo_o    <= 1'b0;
            wd_cnt       <= '0;
`endif
        end else begin
            vsync_d1     <= vsync_i;
            href_d1      <= href_i;
            cap_en_o     <= 1'b0;
            sof_o        <= 1'b0;
            eol_o        <= 1'b0;
            frame_done_o <= 1'b0;
            run_done_o   <= 1'b0;

            // Pixel strobes; a dropped pixel still advances the pixel count
            // so the line-length check is unaffected by backpressure.
            if (pix_take) begin
                if (pix_cnt != '1) pix_cnt <= pix_cnt + PW'(1);
                if (fifo_full_i) begin
                    err_ovf_o <= 1'b1;
                end else begin
                    cap_en_o <= 1'b1;
                    sof_o    <= (pix_cnt == '0) && (line_cnt == '0);
                    eol_o    <= (pix_cnt == PW'(H_ACTIVE - 1));
                end
            end

            case (state)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        state      <= ARM;
                        num_frames <= num_frames_i;
                        frames_o   <= '0;
                        err_hlen_o <= 1'b0;
                        err_vlen_o <= 1'b0;
                        err_ovf_o  <= 1'b0;
`ifdef CAP_SEQ_TIMEOUT_EN
                        err_tmo_o  <= 1'b0;
`endif
                    end
                end
                ARM: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else if (vsync_fall) begin
                        state    <= CAP;
                        pix_cnt  <= '0;
                        line_cnt <= '0;
                    end
                end
                CAP: begin
                    if (href_fall) begin
                        if (pix_cnt != PW'(H_ACTIVE)) err_hlen_o <= 1'b1;
                        if (line_cnt != '1) line_cnt <= line_cnt + LW'(1);
                        pix_cnt <= '0;
                    end
                    // Abort takes precedence over a coincident frame end:
                    // an aborted run never reports completion.
                    if (abort_i) begin
                        state <= DRAIN;
                    end else if (vsync_rise) begin
                        if (line_cnt != LW'(V_ACTIVE)) err_vlen_o <= 1'b1;
                        frame_done_o <= 1'b1;
                        frames_o     <= frames_nxt;
                        if ((num_frames != '0) && (frames_nxt == num_frames)) begin
                            run_done_o <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= ARM;
                        end
                    end
                end
                DRAIN: begin
                    if (!href_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

`ifdef CAP_SEQ_TIMEOUT_EN
            // Watchdog: any vsync edge proves the camera is alive.
            if ((state == ARM) || (state == CAP)) begin
                if (vsync_fall || vsync_rise) begin
                    wd_cnt <= '0;
                end else if (wd_cnt == WW'(TIMEOUT_CYC - 1)) begin
                    wd_cnt       <= '0;
                    err_tmo_o    <= 1'b1;
                    state        <= IDLE;
                    frame_done_o <= 1'b0;
                    run_done_o   <= 1'b0;
                end else begin
                    wd_cnt <= wd_cnt + WW'(1);
                end
            end else begin
                wd_cnt <= '0;
            end
`endif
        end
    end

endmodule
